// File: rtl/seg7_result_decoder.sv
// seg7_result_decoder: debounced inverse of the 3-bit signed 7-segment display encoder.
// A code is accepted only after STABLE_CYCLES identical samples. The decoded value and
// its class (numeric / blank overflow / illegal) are held until the next accept, and each
// accept bumps one of three saturating statistics counters.
module seg7_result_decoder #(
    parameter int STABLE_CYCLES = 3,
    parameter int CNT_W         = 8
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic [7:0]       seg_in,
    input  logic             seg_valid,
    output logic             out_valid,
    output logic [2:0]       val,
    output logic             ovf,
    output logic             illegal,
    output logic [CNT_W-1:0] n_ok,
    output logic [CNT_W-1:0] n_ovf,
    output logic [CNT_W-1:0] n_err
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        EMIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    cap, cap_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          load_dec;
    logic [4:0]    dec_res;

    // Pattern -> {illegal, ovf, val}; the sign segment (bit 7) marks the negative codes.
    function automatic logic [4:0] decode_seg(input logic [7:0] code);
        logic [4:0] r;
        case (code)
            8'h3F:   r = {2'b00, 3'b000};
            8'h06:   r = {2'b00, 3'b001};
            8'h5B:   r = {2'b00, 3'b010};
            8'h4F:   r = {2'b00, 3'b011};
            8'hE6:   r = {2'b00, 3'b100};
            8'hCF:   r = {2'b00, 3'b101};
            8'hDB:   r = {2'b00, 3'b110};
            8'h86:   r = {2'b00, 3'b111};
            8'h00:   r = {2'b01, 3'b000};
            default: r = {2'b10, 3'b000};
        endcase
        return r;
    endfunction

    // Saturating increment: a counter at all-ones stays there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    assign dec_res = decode_seg(cap);

    // Next-state and capture/qualification-counter logic.
    always_comb begin
        state_nxt = state;
        cap_nxt   = cap;
        cnt_nxt   = cnt;
        load_dec  = 1'b0;
        case (state)
            IDLE: begin
                if (seg_valid) begin
                    cap_nxt   = seg_in;
                    cnt_nxt   = CNT_ONE;
                    state_nxt = QUAL;
                end
            end
            QUAL: begin
                if (!seg_valid) begin
                    state_nxt = IDLE;
                end else if (seg_in != cap) begin
                    cap_nxt = seg_in;
                    cnt_nxt = CNT_ONE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = EMIT;
                    load_dec  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            EMIT: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (!seg_valid) begin
                    state_nxt = IDLE;
                end else if (seg_in != cap) begin
                    cap_nxt   = seg_in;
                    cnt_nxt   = CNT_ONE;
                    state_nxt = QUAL;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, capture and registered outputs; statistics update on the cycle spent in EMIT.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state     <= IDLE;
            cap       <= 8'h00;
            cnt       <= '0;
            out_valid <= 1'b0;
            val       <= 3'b000;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
            n_ok      <= '0;
            n_ovf     <= '0;
            n_err     <= '0;
        end else begin
            state     <= state_nxt;
            cap       <= cap_nxt;
            cnt       <= cnt_nxt;
            out_valid <= (state_nxt == EMIT);
            if (load_dec) begin
                illegal <= dec_res[4];
                ovf     <= dec_res[3];
                val     <= dec_res[2:0];
            end
            if (state == EMIT) begin
                if (illegal)  n_err <= sat_inc(n_err);
                else if (ovf) n_ovf <= sat_inc(n_ovf);
                else          n_ok  <= sat_inc(n_ok);
            end
        end
    end

endmodule

// File: tb/tb_seg7_result_decoder.sv
// Directed bench for seg7_result_decoder: linear stimulus with immediate-assertion checks.
module tb_seg7_result_decoder;

    localparam int STABLE_CYCLES = 3;
    localparam int CNT_W         = 8;

    logic             clk_2;
    logic             reset;
    logic [7:0]       seg_in;
    logic             seg_valid;
    logic             out_valid;
    logic [2:0]       val;
    logic             ovf;
    logic             illegal;
    logic [CNT_W-1:0] n_ok;
    logic [CNT_W-1:0] n_ovf;
    logic [CNT_W-1:0] n_err;

    int checks   = 0;
    int failures = 0;
    int pulses;

    seg7_result_decoder #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk_2    (clk_2),
        .reset    (reset),
        .seg_in   (seg_in),
        .seg_valid(seg_valid),
        .out_valid(out_valid),
        .val      (val),
        .ovf      (ovf),
        .illegal  (illegal),
        .n_ok     (n_ok),
        .n_ovf    (n_ovf),
        .n_err    (n_err)
    );

    // 10 ns clock
    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 ns after the rising edge.
    task automatic step();
        @(posedge clk_2);
        #1;
    endtask

    // Pulse must be absent for n-1 cycles and present on cycle n.
    task automatic expect_pulse_at(input string tag, input int n);
        for (int i = 1; i < n; i++) begin
            step();
            check({tag, "_early"}, out_valid, 0);
        end
        step();
        check({tag, "_pulse"}, out_valid, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vld"}, out_valid, 0);
        check({tag, "_val"}, val, 0);
        check({tag, "_flags"}, {ovf, illegal}, 0);
        check({tag, "_cnts"}, {n_ok, n_ovf, n_err}, 0);
    endtask

    initial begin
        assert (STABLE_CYCLES >= 2) else $fatal(1, "FAIL param STABLE_CYCLES=%0d exp>=2", STABLE_CYCLES);

        reset     = 1'b1;
        seg_in    = 8'h00;
        seg_valid = 1'b0;
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;

        // 1: 5B held -> pulse in cycle 3, no re-count while held
        seg_in = 8'h5B; seg_valid = 1'b1;
        expect_pulse_at("t1", 3);
        check("t1_val", val, 3'b010);
        check("t1_flags", {ovf, illegal}, 2'b00);
        step();
        check("t1_nok", n_ok, 1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) pulses++;
        end
        check("t1_no_repulse", pulses, 0);
        check("t1_nok_held", n_ok, 1);

        // 2: CF -> -3, 00 -> overflow blank, 12 -> illegal
        seg_in = 8'hCF;
        expect_pulse_at("t2a", 3);
        check("t2a_val", val, 3'b101);
        step();
        check("t2a_nok", n_ok, 2);
        seg_in = 8'h00;
        expect_pulse_at("t2b", 3);
        check("t2b_val", val, 3'b000);
        check("t2b_ovf", ovf, 1);
        check("t2b_ill", illegal, 0);
        step();
        check("t2b_novf", n_ovf, 1);
        seg_in = 8'h12;
        expect_pulse_at("t2c", 3);
        check("t2c_ill", illegal, 1);
        check("t2c_ovf", ovf, 0);
        check("t2c_val", val, 3'b000);
        step();
        check("t2c_nerr", n_err, 1);
        check("t2c_nok", n_ok, 2);

        // 3: 06 glitch for 2 cycles, then 4F held
        seg_in = 8'h06;
        step(); check("t3_glitch1", out_valid, 0);
        step(); check("t3_glitch2", out_valid, 0);
        seg_in = 8'h4F;
        expect_pulse_at("t3", 3);
        check("t3_val", val, 3'b011);
        check("t3_flags", {ovf, illegal}, 2'b00);
        step();
        check("t3_nok", n_ok, 3);

        // 4: drop seg_valid on the final qualification sample of 3F -> no accept
        seg_valid = 1'b0;
        step();
        seg_in = 8'h3F; seg_valid = 1'b1;
        step(); check("t4_q1", out_valid, 0);
        step(); check("t4_q2", out_valid, 0);
        seg_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid) pulses++;
        end
        check("t4_drop_pulses", pulses, 0);
        check("t4_drop_cnts", {n_ok, n_ovf, n_err}, {8'd3, 8'd1, 8'd1});
        check("t4_drop_val", val, 3'b011);
        // 86 reacquired twice after seg_valid toggles
        seg_in = 8'h86; seg_valid = 1'b1;
        expect_pulse_at("t4a", 3);
        check("t4a_val", val, 3'b111);
        step();
        check("t4a_nok", n_ok, 4);
        seg_valid = 1'b0;
        step();
        seg_valid = 1'b1;
        expect_pulse_at("t4b", 3);
        step();
        check("t4b_nok", n_ok, 5);

        // 5: run n_ok up to saturation and one beyond
        pulses = 0;
        for (int i = 0; i < 251; i++) begin
            seg_valid = 1'b0;
            step();
            seg_valid = 1'b1;
            for (int j = 0; j < 4; j++) begin
                step();
                if (out_valid) pulses++;
            end
        end
        check("t5_pulses", pulses, 251);
        check("t5_nok_sat", n_ok, 8'hFF);
        check("t5_novf", n_ovf, 1);
        check("t5_nerr", n_err, 1);

        // 6: reset in QUAL, then reset in EMIT
        seg_valid = 1'b0;
        step();
        seg_in = 8'h3F; seg_valid = 1'b1;
        step();
        reset = 1'b1;
        step();
        check_all_zero("t6_rst_qual");
        reset = 1'b0; seg_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid) pulses++;
        end
        check("t6_qual_nopulse", pulses, 0);
        seg_in = 8'hDB; seg_valid = 1'b1;
        expect_pulse_at("t6", 3);
        check("t6_val", val, 3'b110);
        reset = 1'b1;
        step();
        check_all_zero("t6_rst_emit");
        reset = 1'b0; seg_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid) pulses++;
        end
        check("t6_emit_nopulse", pulses, 0);
        check("t6_emit_nok", n_ok, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
